// File: rtl/bp_pkg.sv
// ============================================================================
// bp_pkg : shared constants and saturating-counter helpers for the BTB
// Revision: 1.0
// ============================================================================
`default_nettype none

package bp_pkg;

  localparam int XLEN_DEF  = 32;
  localparam int CTR_MAX_W = 4;

  function automatic logic [CTR_MAX_W-1:0] ctr_ones(input int bits);
    return CTR_MAX_W'((1 << bits) - 1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_wt(input int bits);
    return CTR_MAX_W'(1 << (bits - 1));
  endfunction

  function automatic logic [CTR_MAX_W-1:0] ctr_wnt(input int bits);
    return ctr_wt(bits) - CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_inc(input logic [CTR_MAX_W-1:0] v, input int bits);
    return (v == ctr_ones(bits)) ? v : v + CTR_MAX_W'(1);
  endfunction

  function automatic logic [CTR_MAX_W-1:0] sat_dec(input logic [CTR_MAX_W-1:0] v, input int bits);
    return (v == '0) ? v : v - CTR_MAX_W'(1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bp_sat_ctr.sv
// ============================================================================
// bp_sat_ctr : saturating up/down direction counter with parallel load
// Revision: 1.0
// ============================================================================
`default_nettype none

module bp_sat_ctr
  import bp_pkg::*;
#(
  parameter int                CTR_BITS = 2,
  parameter logic [CTR_BITS-1:0] RST_VAL  = '0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inc,
  input  logic                dec,
  input  logic                load,
  input  logic [CTR_BITS-1:0] load_val,
  output logic [CTR_BITS-1:0] cnt
);

  logic [CTR_BITS-1:0] cnt_q;
  logic [CTR_BITS-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      cnt_d = CTR_BITS'(sat_inc(CTR_MAX_W'(cnt_q), CTR_BITS));
    end else if (dec) begin
      cnt_d = CTR_BITS'(sat_dec(CTR_MAX_W'(cnt_q), CTR_BITS));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= RST_VAL;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

`default_nettype wire

// File: rtl/branch_target_predictor.sv
// ============================================================================
// branch_target_predictor : direct-mapped BTB with per-entry direction counters
// Revision: 1.0
// ============================================================================
`default_nettype none

module branch_target_predictor
  import bp_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int ENTRIES  = 16,
  parameter int CTR_BITS = 2,
  parameter int STAT_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [XLEN-1:0]   pc_if,
  output logic              pred_taken,
  output logic [XLEN-1:0]   pred_target,
  input  logic              upd_en,
  input  logic [XLEN-1:0]   upd_pc,
  input  logic              upd_taken,
  input  logic              upd_uncond,
  input  logic [XLEN-1:0]   upd_target,
  input  logic              upd_mispred,
  input  logic              inval,
  output logic [STAT_W-1:0] stat_upd,
  output logic [STAT_W-1:0] stat_mis
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;
  localparam logic [CTR_BITS-1:0] CTR_WT   = CTR_BITS'(ctr_wt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_WNT  = CTR_BITS'(ctr_wnt(CTR_BITS));
  localparam logic [CTR_BITS-1:0] CTR_ONES = CTR_BITS'(ctr_ones(CTR_BITS));

  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [TAG_W-1:0]   tag_d    [ENTRIES];
  logic [XLEN-1:0]    target_q [ENTRIES];
  logic [XLEN-1:0]    target_d [ENTRIES];
  logic [CTR_BITS-1:0] w_ctr   [ENTRIES];
  logic [STAT_W-1:0]  stat_upd_q, stat_upd_d;
  logic [STAT_W-1:0]  stat_mis_q, stat_mis_d;

  logic [IDX_W-1:0]    w_if_idx, w_upd_idx;
  logic [TAG_W-1:0]    w_if_tag, w_upd_tag;
  logic                w_if_hit, w_upd_hit, w_upd_tkn;
  logic                w_wr, w_alloc, w_hit_wr;
  logic [CTR_BITS-1:0] w_load_val;
  logic [3:0]          w_unused_pc_lsbs;

  assign w_unused_pc_lsbs = {pc_if[1:0], upd_pc[1:0]};

  // Read port: pure lookup of pre-edge table contents.
  assign w_if_idx    = pc_if[IDX_W+1:2];
  assign w_if_tag    = pc_if[XLEN-1:IDX_W+2];
  assign w_if_hit    = valid_q[w_if_idx] && (tag_q[w_if_idx] == w_if_tag);
  assign pred_taken  = w_if_hit && w_ctr[w_if_idx][CTR_BITS-1];
  assign pred_target = pred_taken ? target_q[w_if_idx] : pc_if + XLEN'(4);

  assign w_upd_idx  = upd_pc[IDX_W+1:2];
  assign w_upd_tag  = upd_pc[XLEN-1:IDX_W+2];
  assign w_upd_hit  = valid_q[w_upd_idx] && (tag_q[w_upd_idx] == w_upd_tag);
  assign w_upd_tkn  = upd_taken | upd_uncond;
  assign w_wr       = upd_en & ~inval;
  assign w_alloc    = w_wr & ~w_upd_hit & w_upd_tkn;
  assign w_hit_wr   = w_wr & w_upd_hit;
  assign w_load_val = upd_uncond ? CTR_ONES : CTR_WT;

  generate
    for (genvar i = 0; i < ENTRIES; i++) begin : g_ctr
      logic w_sel;
      assign w_sel = (w_upd_idx == IDX_W'(i));
      bp_sat_ctr #(
        .CTR_BITS (CTR_BITS),
        .RST_VAL  (CTR_WNT)
      ) u_ctr (
        .clk      (clk),
        .rst      (rst),
        .inc      (w_sel & w_hit_wr & ~upd_uncond & upd_taken),
        .dec      (w_sel & w_hit_wr & ~upd_uncond & ~upd_taken),
        .load     (w_sel & (w_alloc | (w_hit_wr & upd_uncond))),
        .load_val (w_load_val),
        .cnt      (w_ctr[i])
      );
    end
  endgenerate

  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (inval) begin
      valid_d = '0;
    end else if (w_alloc) begin
      valid_d[w_upd_idx] = 1'b1;
      tag_d[w_upd_idx]   = w_upd_tag;
    end
    if (w_wr && w_upd_tkn) begin
      target_d[w_upd_idx] = upd_target;
    end
  end

  always_comb begin
    stat_upd_d = stat_upd_q;
    stat_mis_d = stat_mis_q;
    if (upd_en && (stat_upd_q != {STAT_W{1'b1}})) begin
      stat_upd_d = stat_upd_q + STAT_W'(1);
    end
    if (upd_en && upd_mispred && (stat_mis_q != {STAT_W{1'b1}})) begin
      stat_mis_d = stat_mis_q + STAT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      stat_upd_q <= '0;
      stat_mis_q <= '0;
      for (int i = 0; i < ENTRIES; i++) begin
        tag_q[i]    <= '0;
        target_q[i] <= '0;
      end
    end else begin
      valid_q    <= valid_d;
      stat_upd_q <= stat_upd_d;
      stat_mis_q <= stat_mis_d;
      tag_q      <= tag_d;
      target_q   <= target_d;
    end
  end

  assign stat_upd = stat_upd_q;
  assign stat_mis = stat_mis_q;

endmodule

`default_nettype wire

// File: tb/tb_branch_target_predictor.sv
// ============================================================================
// tb_branch_target_predictor : directed self-checking bench for the BTB
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_branch_target_predictor;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_if;
  logic        upd_en, upd_taken, upd_uncond, upd_mispred, inval;
  logic [31:0] upd_pc, upd_target;
  logic        pred_taken, pred_taken_s;
  logic [31:0] pred_target, pred_target_s;
  logic [15:0] stat_upd, stat_mis;
  logic [1:0]  stat_upd_s, stat_mis_s;

  int n_checks = 0;
  int n_fail   = 0;
  int exp_upd  = 0;
  int exp_mis  = 0;

  always #5 clk = ~clk;

  branch_target_predictor u_dut (
    .clk (clk), .rst (rst), .pc_if (pc_if),
    .pred_taken (pred_taken), .pred_target (pred_target),
    .upd_en (upd_en), .upd_pc (upd_pc), .upd_taken (upd_taken),
    .upd_uncond (upd_uncond), .upd_target (upd_target),
    .upd_mispred (upd_mispred), .inval (inval),
    .stat_upd (stat_upd), .stat_mis (stat_mis)
  );

  branch_target_predictor #(.STAT_W(2)) u_dut_s (
    .clk (clk), .rst (rst), .pc_if (pc_if),
    .pred_taken (pred_taken_s), .pred_target (pred_target_s),
    .upd_en (upd_en), .upd_pc (upd_pc), .upd_taken (upd_taken),
    .upd_uncond (upd_uncond), .upd_target (upd_target),
    .upd_mispred (upd_mispred), .inval (inval),
    .stat_upd (stat_upd_s), .stat_mis (stat_mis_s)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic lookup(input string tag, input logic [31:0] pc,
                        input logic exp_tkn, input logic [31:0] exp_tgt);
    pc_if = pc;
    #1;
    chk({tag, "_taken"},  {31'd0, pred_taken}, {31'd0, exp_tkn});
    chk({tag, "_target"}, pred_target, exp_tgt);
  endtask

  task automatic chk_stats(input string tag);
    chk({tag, "_stat_upd"},   {16'd0, stat_upd},   exp_upd);
    chk({tag, "_stat_mis"},   {16'd0, stat_mis},   exp_mis);
    chk({tag, "_stat_upd_s"}, {30'd0, stat_upd_s}, (exp_upd > 3) ? 3 : exp_upd);
    chk({tag, "_stat_mis_s"}, {30'd0, stat_mis_s}, (exp_mis > 3) ? 3 : exp_mis);
  endtask

  // Drives one resolution for a single clock edge, optionally with inval.
  task automatic upd(input logic [31:0] pc, input logic tkn, input logic unc,
                     input logic [31:0] tgt, input logic mis, input logic inv);
    upd_en = 1'b1; upd_pc = pc; upd_taken = tkn; upd_uncond = unc;
    upd_target = tgt; upd_mispred = mis; inval = inv;
    @(posedge clk);
    #1;
    upd_en = 1'b0; upd_taken = 1'b0; upd_uncond = 1'b0; upd_mispred = 1'b0; inval = 1'b0;
    exp_upd++;
    if (mis) exp_mis++;
  endtask

  initial begin
    rst = 1'b1; pc_if = 32'h40; upd_en = 1'b0; upd_pc = '0; upd_taken = 1'b0;
    upd_uncond = 1'b0; upd_target = '0; upd_mispred = 1'b0; inval = 1'b0;
    #12;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Reset state
    lookup("rst", 32'h40, 1'b0, 32'h44);
    chk_stats("rst");

    // Allocation as weak taken
    upd(32'h40, 1'b1, 1'b0, 32'h100, 1'b1, 1'b0);
    lookup("alloc", 32'h40, 1'b1, 32'h100);

    // Decrement down to and saturating at zero
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    lookup("nt1", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    upd(32'h40, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    upd(32'h40, 1'b1, 1'b0, 32'h120, 1'b1, 1'b0);
    lookup("sat0_t1", 32'h40, 1'b0, 32'h44);
    upd(32'h40, 1'b1, 1'b0, 32'h120, 1'b0, 1'b0);
    lookup("sat0_t2", 32'h40, 1'b1, 32'h120);
    chk_stats("mid");

    // Aliasing on index 0, and not-taken miss leaves table alone
    upd(32'h80, 1'b1, 1'b0, 32'h200, 1'b1, 1'b0);
    lookup("alias_old", 32'h40, 1'b0, 32'h44);
    lookup("alias_new", 32'h80, 1'b1, 32'h200);
    upd(32'hC4, 1'b0, 1'b0, 32'h400, 1'b0, 1'b0);
    lookup("nt_miss", 32'hC4, 1'b0, 32'hC8);
    lookup("nt_miss_80", 32'h80, 1'b1, 32'h200);

    // Unconditional allocation loads strong taken
    upd(32'h104, 1'b0, 1'b1, 32'h500, 1'b0, 1'b0);
    lookup("uncond", 32'h104, 1'b1, 32'h500);
    upd(32'h104, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    lookup("uncond_nt", 32'h104, 1'b1, 32'h500);

    // Invalidate, then same-cycle lookup/update
    inval = 1'b1;
    @(posedge clk);
    #1;
    inval = 1'b0;
    lookup("inval", 32'h80, 1'b0, 32'h84);
    pc_if = 32'h40;
    upd_en = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1; upd_target = 32'h100;
    #1;
    chk("same_cyc_taken", {31'd0, pred_taken}, 32'd0);
    @(posedge clk);
    #1;
    upd_en = 1'b0; upd_taken = 1'b0;
    exp_upd++;
    lookup("same_cyc_next", 32'h40, 1'b1, 32'h100);

    // inval beats simultaneous allocation but statistics still count
    upd(32'h80, 1'b1, 1'b0, 32'h200, 1'b1, 1'b1);
    lookup("inv_upd_40", 32'h40, 1'b0, 32'h44);
    lookup("inv_upd_80", 32'h80, 1'b0, 32'h84);
    chk_stats("inv_upd");

    // Asynchronous reset mid-training
    upd(32'h40, 1'b1, 1'b0, 32'h100, 1'b0, 1'b0);
    lookup("pre_rst", 32'h40, 1'b1, 32'h100);
    #2;
    rst = 1'b1;
    #1;
    exp_upd = 0; exp_mis = 0;
    lookup("async_rst", 32'h40, 1'b0, 32'h44);
    chk_stats("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Statistics and small-counter saturation
    upd(32'h200, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    upd(32'h204, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    upd(32'h208, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    chk_stats("stats3");
    upd(32'h20C, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    upd(32'h210, 1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    chk_stats("stats5");
    chk("small_sat_upd", {30'd0, stat_upd_s}, 32'd3);
    lookup("no_alloc", 32'h200, 1'b0, 32'h204);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
